// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for the elastic writeback stage: upstream beat, flush,
// and downstream beat. The stage itself connects through the slave modport.
interface pipe_stage_elastic_if #(
    parameter int CTRL_W  = 8,
    parameter int DATA_W  = 64,
    parameter int ALIGN_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [CTRL_W-1:0]  in_ctrl;
    logic [DATA_W-1:0]  in_data;
    logic [ALIGN_W-1:0] in_align;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [CTRL_W-1:0]  out_ctrl;
    logic [DATA_W-1:0]  out_data;
    logic [ALIGN_W-1:0] out_align;

    modport master (
        output in_valid, in_ctrl, in_data, in_align, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, out_align
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, in_align, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, out_align
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage in front of writeback. Holds up to two beats
// (main + skid) when SKID=1, or one beat when SKID=0. Flush discards held
// beats and is counted; downstream back-pressure cycles are counted.
module pipe_stage_elastic #(
    parameter int CTRL_W  = 8,
    parameter int DATA_W  = 64,
    parameter int ALIGN_W = 32,
    parameter int SKID    = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_elastic_if.slave  bus,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t             state;
    logic [CTRL_W-1:0]  main_ctrl,  skid_ctrl;
    logic [DATA_W-1:0]  main_data,  skid_data;
    logic [ALIGN_W-1:0] main_align, skid_align;

    logic       has_beat;
    logic       out_valid;
    logic       in_ready;
    logic       in_xfer;
    logic       out_xfer;
    logic [1:0] occ;

    // Saturating accumulate: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [1:0] inc);
        logic [CNT_W:0] ext;
        logic [CNT_W:0] sum;
        ext      = '0;
        ext[1:0] = inc;
        sum      = {1'b0, acc} + ext;
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign has_beat = (state != EMPTY);
    assign occ      = (state == TWO) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);

    // Reset and flush both mask the handshake outputs combinationally so no
    // beat can move while the stage is being cleared.
    assign out_valid = rst && !bus.flush && has_beat;

    generate
        if (SKID != 0) begin : g_skid
            // Skid slot absorbs the beat in flight, so ready depends only on state.
            assign in_ready = rst && !bus.flush && (state != TWO);
        end else begin : g_single
            // Single slot: accept only when the held beat leaves this cycle.
            assign in_ready = rst && !bus.flush && (!has_beat || bus.out_ready);
        end
    endgenerate

    assign in_xfer  = bus.in_valid && in_ready;
    assign out_xfer = out_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_ctrl  = main_ctrl;
    assign bus.out_data  = main_data;
    assign bus.out_align = main_align;

    // Occupancy FSM, payload registers and performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= EMPTY;
            main_ctrl  <= '0;
            main_data  <= '0;
            main_align <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            skid_align <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            if (out_valid && !bus.out_ready) begin
                stall_cnt <= sat_add(stall_cnt, 2'd1);
            end
            if (bus.flush) begin
                state     <= EMPTY;
                flush_cnt <= sat_add(flush_cnt, occ);
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_xfer) begin
                            main_ctrl  <= bus.in_ctrl;
                            main_data  <= bus.in_data;
                            main_align <= bus.in_align;
                            state      <= ONE;
                        end
                    end
                    ONE: begin
                        if (in_xfer && out_xfer) begin
                            main_ctrl  <= bus.in_ctrl;
                            main_data  <= bus.in_data;
                            main_align <= bus.in_align;
                        end else if (in_xfer) begin
                            skid_ctrl  <= bus.in_ctrl;
                            skid_data  <= bus.in_data;
                            skid_align <= bus.in_align;
                            state      <= TWO;
                        end else if (out_xfer) begin
                            state <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (out_xfer) begin
                            main_ctrl  <= skid_ctrl;
                            main_data  <= skid_data;
                            main_align <= skid_align;
                            state      <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: scoreboarded SKID=1 instance plus directed
// SKID=0 and narrow-counter (CNT_W=4) instances.
module tb_pipe_stage_elastic;
    typedef struct packed {
        logic [7:0]  c;
        logic [63:0] d;
        logic [31:0] a;
    } beat_t;

    logic       clk;
    logic       rst;
    logic [15:0] stall_a, flush_a, stall_b, flush_b;
    logic [3:0]  stall_c, flush_c;
    int         checks;
    int         errors;
    beat_t      exp_q[$];

    pipe_stage_elastic_if #(.CTRL_W(8), .DATA_W(64), .ALIGN_W(32)) a_if ();
    pipe_stage_elastic_if #(.CTRL_W(8), .DATA_W(64), .ALIGN_W(32)) b_if ();
    pipe_stage_elastic_if #(.CTRL_W(8), .DATA_W(64), .ALIGN_W(32)) c_if ();

    pipe_stage_elastic #(.SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .bus(a_if), .stall_cnt(stall_a), .flush_cnt(flush_a));
    pipe_stage_elastic #(.SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .bus(b_if), .stall_cnt(stall_b), .flush_cnt(flush_b));
    pipe_stage_elastic #(.SKID(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .bus(c_if), .stall_cnt(stall_c), .flush_cnt(flush_c));

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one upstream beat on instance A; payload fields derived from d.
    task automatic put_a(input logic v, input logic [63:0] d, input logic push);
        beat_t b;
        b.c = d[7:0] ^ 8'h5A;
        b.d = d;
        b.a = d[31:0] + 32'h1000;
        a_if.in_valid = v;
        a_if.in_ctrl  = b.c;
        a_if.in_data  = b.d;
        a_if.in_align = b.a;
        if (push) exp_q.push_back(b);
    endtask

    task automatic init_if();
        a_if.in_valid = 0; a_if.in_ctrl = '0; a_if.in_data = '0; a_if.in_align = '0;
        a_if.flush = 0; a_if.out_ready = 0;
        b_if.in_valid = 0; b_if.in_ctrl = '0; b_if.in_data = '0; b_if.in_align = '0;
        b_if.flush = 0; b_if.out_ready = 0;
        c_if.in_valid = 0; c_if.in_ctrl = '0; c_if.in_data = '0; c_if.in_align = '0;
        c_if.flush = 0; c_if.out_ready = 0;
    endtask

    // Stimulus and scoreboard monitor run side by side in one process.
    initial begin
        clk = 0;
        rst = 0;
        checks = 0;
        errors = 0;
        init_if();
        fork
            begin : stim
                // Reset: beat offered during reset must not be taken.
                put_a(1, 64'hDEAD, 0);
                repeat (3) tick();
                chk("rst_in_ready", a_if.in_ready, 0);
                chk("rst_out_valid", a_if.out_valid, 0);
                chk("rst_out_data", a_if.out_data, 0);
                chk("rst_stall_cnt", stall_a, 0);
                chk("rst_flush_cnt", flush_a, 0);
                put_a(0, 0, 0);
                rst = 1;

                // Streaming, latency 1, full throughput.
                a_if.out_ready = 1;
                for (int i = 1; i <= 8; i++) begin
                    put_a(1, 64'(i), 1);
                    #1 chk("stream_in_ready", a_if.in_ready, 1);
                    tick();
                    chk("stream_out_data", a_if.out_data, 64'(i));
                    chk("stream_out_valid", a_if.out_valid, 1);
                end
                put_a(0, 0, 0);
                tick();
                chk("stream_drained", a_if.out_valid, 0);
                chk("stream_stall_cnt", stall_a, 0);

                // Fill to TWO under back-pressure, then drain in order.
                a_if.out_ready = 0;
                put_a(1, 64'hA, 1);
                #1 chk("fill_in_ready_empty", a_if.in_ready, 1);
                tick();
                put_a(1, 64'hB, 1);
                #1 chk("fill_in_ready_one", a_if.in_ready, 1);
                tick();
                put_a(1, 64'hCC, 0);
                #1 chk("two_in_ready", a_if.in_ready, 0);
                chk("two_out_data", a_if.out_data, 64'hA);
                chk("two_stall_cnt", stall_a, 1);
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk("hold_stall_cnt", stall_a, 64'(2 + k));
                    chk("hold_out_data", a_if.out_data, 64'hA);
                    chk("hold_in_ready", a_if.in_ready, 0);
                end
                put_a(0, 0, 0);
                a_if.out_ready = 1;
                tick();
                chk("drain_second", a_if.out_data, 64'hB);
                chk("drain_stall_cnt", stall_a, 4);
                tick();
                chk("drain_empty", a_if.out_valid, 0);
                chk("idle_data_held", a_if.out_data, 64'hB);

                // Flush in TWO with downstream ready: nothing delivered, counts 2.
                a_if.out_ready = 0;
                put_a(1, 64'h11, 0);
                tick();
                put_a(1, 64'h22, 0);
                tick();
                put_a(0, 0, 0);
                chk("pre_flush_stall", stall_a, 5);
                a_if.flush = 1;
                a_if.out_ready = 1;
                #1 chk("flush_out_valid", a_if.out_valid, 0);
                chk("flush_in_ready", a_if.in_ready, 0);
                tick();
                a_if.flush = 0;
                chk("post_flush_valid", a_if.out_valid, 0);
                chk("flush_cnt_two", flush_a, 2);
                chk("flush_no_stall", stall_a, 5);
                a_if.flush = 1;
                tick();
                a_if.flush = 0;
                chk("flush_cnt_empty", flush_a, 2);
                a_if.out_ready = 0;
                put_a(1, 64'h33, 0);
                tick();
                put_a(0, 0, 0);
                a_if.flush = 1;
                tick();
                a_if.flush = 0;
                chk("flush_cnt_one", flush_a, 3);
                chk("flush_one_stall", stall_a, 5);

                // Reset wins over flush while holding a beat.
                put_a(1, 64'h44, 0);
                tick();
                put_a(0, 0, 0);
                rst = 0;
                a_if.flush = 1;
                #1 chk("rst_gate_valid", a_if.out_valid, 0);
                chk("rst_gate_ready", a_if.in_ready, 0);
                tick();
                rst = 1;
                a_if.flush = 0;
                chk("rst2_out_valid", a_if.out_valid, 0);
                chk("rst2_out_data", a_if.out_data, 0);
                chk("rst2_ctrl_align", {a_if.out_ctrl, a_if.out_align}, 0);
                chk("rst2_stall_cnt", stall_a, 0);
                chk("rst2_flush_cnt", flush_a, 0);

                // First cycle out of reset accepts a beat.
                a_if.out_ready = 1;
                put_a(1, 64'h55, 1);
                #1 chk("first_in_ready", a_if.in_ready, 1);
                tick();
                chk("first_out_data", a_if.out_data, 64'h55);
                put_a(0, 0, 0);
                tick();
                chk("first_drained", a_if.out_valid, 0);

                // SKID=0: ready follows out_ready combinationally.
                b_if.out_ready = 0;
                b_if.in_valid = 1;
                b_if.in_data = 64'h61;
                #1 chk("b_ready_empty", b_if.in_ready, 1);
                tick();
                b_if.in_data = 64'h62;
                #1 chk("b_ready_blocked", b_if.in_ready, 0);
                tick();
                chk("b_held", b_if.out_data, 64'h61);
                b_if.out_ready = 1;
                #1 chk("b_ready_same_cycle", b_if.in_ready, 1);
                tick();
                chk("b_replaced", b_if.out_data, 64'h62);
                chk("b_valid", b_if.out_valid, 1);
                b_if.in_data = 64'h63;
                tick();
                chk("b_stream", b_if.out_data, 64'h63);
                b_if.in_valid = 0;
                tick();
                chk("b_empty", b_if.out_valid, 0);
                chk("b_stall_cnt", stall_b, 1);
                b_if.out_ready = 0;
                b_if.in_valid = 1;
                b_if.in_data = 64'h64;
                tick();
                b_if.in_valid = 0;
                b_if.flush = 1;
                tick();
                b_if.flush = 0;
                chk("b_flush_cnt", flush_b, 1);
                chk("b_flush_valid", b_if.out_valid, 0);

                // CNT_W=4: both counters saturate at 15.
                c_if.out_ready = 0;
                c_if.in_valid = 1;
                c_if.in_data = 64'h71;
                tick();
                c_if.in_valid = 0;
                repeat (20) tick();
                chk("c_stall_sat", stall_c, 15);
                tick();
                chk("c_stall_hold", stall_c, 15);
                c_if.flush = 1;
                tick();
                c_if.flush = 0;
                chk("c_flush_one", flush_c, 1);
                for (int k = 0; k < 8; k++) begin
                    c_if.in_valid = 1;
                    repeat (2) tick();
                    c_if.in_valid = 0;
                    c_if.flush = 1;
                    tick();
                    c_if.flush = 0;
                end
                chk("c_flush_sat", flush_c, 15);
                repeat (2) tick();
            end
            begin : mon
                beat_t e;
                forever begin
                    @(negedge clk);
                    if (a_if.out_valid && a_if.out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL sb_unexpected: got beat 0x%0h, expected none",
                                     a_if.out_data);
                        end else begin
                            e = exp_q.pop_front();
                            chk("sb_beat", {a_if.out_ctrl, a_if.out_data, a_if.out_align}, e);
                        end
                    end
                end
            end
        join_any
        disable fork;
        chk("sb_all_delivered", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
